ex_alu: RTL and testbench

//  Execute stage that consumes the ID/EX register outputs (opcode, funct3, funct7[5], operands, rd, we).
//  It computes the RV32I integer ALU result and presents it to EX/MEM through a registered valid/ready output slot.

---
 rtl/ex_alu.sv | 181 ++++++++++++++++++
 tb/tb_ex_alu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu.sv
// RV32I execute-stage ALU with a registered valid/ready result slot and a one-bit-per-cycle shifter.
// Define EX_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
`timescale 1ns/1ps
module ex_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_t,
    input  logic [2:0]      in_st,
    input  logic            in_sst,
    input  logic [XLEN-1:0] in_n1,
    input  logic [XLEN-1:0] in_n2,
    input  logic [4:0]      in_wa,
    input  logic            in_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic [4:0]      out_wa,
    output logic            out_we
);
    localparam int SW = $clog2(XLEN);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    logic            is_op;
    logic            is_alu;
    logic            is_shift;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] shl_res;
    logic [XLEN-1:0] shr_res;
    logic [XLEN-1:0] alu_res;
    logic            alu_we;
    logic            slot_free;
    logic            accept;

    logic            out_valid_reg;
    logic [XLEN-1:0] out_res_reg;
    logic [4:0]      out_wa_reg;
    logic            out_we_reg;

    assign is_op     = (in_t == OPC_OP);
    assign is_alu    = is_op || (in_t == OPC_IMM);
    assign is_shift  = is_alu && ((in_st == 3'b001) || (in_st == 3'b101));
    assign shamt     = in_n2[SW-1:0];
    assign slot_free = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_reg;
    assign out_res   = out_res_reg;
    assign out_wa    = out_wa_reg;
    assign out_we    = out_we_reg;

`ifdef EX_FAST_SHIFT_EN
    logic signed [XLEN-1:0] sra_val;

    // Kept as a separate signed net so the unsigned mux below cannot demote >>> to >>.
    assign sra_val = $signed(in_n1) >>> shamt;
    assign shl_res = in_n1 << shamt;
    assign shr_res = in_sst ? sra_val : (in_n1 >> shamt);
`else
    // Only a zero shift amount completes in the accept cycle, and that result is n1.
    assign shl_res = in_n1;
    assign shr_res = in_n1;
`endif

    always_comb begin
        alu_res = '0;
        alu_we  = in_we;
        if (in_t == OPC_LUI) begin
            alu_res = in_n2;
        end else if (is_alu) begin
            unique case (in_st)
                3'b000: alu_res = (is_op && in_sst) ? (in_n1 - in_n2) : (in_n1 + in_n2);
                3'b001: alu_res = shl_res;
                3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(in_n1) < $signed(in_n2))};
                3'b011: alu_res = {{(XLEN-1){1'b0}}, (in_n1 < in_n2)};
                3'b100: alu_res = in_n1 ^ in_n2;
                3'b101: alu_res = shr_res;
                3'b110: alu_res = in_n1 | in_n2;
                3'b111: alu_res = in_n1 & in_n2;
            endcase
        end else begin
            alu_we = 1'b0;
        end
    end

`ifdef EX_FAST_SHIFT_EN
    assign in_ready = rst && !flush && slot_free;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_res_reg   <= '0;
            out_wa_reg    <= '0;
            out_we_reg    <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_res_reg   <= alu_res;
            out_wa_reg    <= in_wa;
            out_we_reg    <= alu_we;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end
`else
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]      state_reg;
    logic [SW-1:0]   cnt_reg;
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] acc_step;
    logic            left_reg;
    logic            arith_reg;
    logic [4:0]      sh_wa_reg;
    logic            sh_we_reg;

    assign in_ready = rst && (state_reg == IDLE) && !flush && slot_free;
    assign acc_step = left_reg ? {acc_reg[XLEN-2:0], 1'b0}
                               : {arith_reg & acc_reg[XLEN-1], acc_reg[XLEN-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            left_reg      <= 1'b0;
            arith_reg     <= 1'b0;
            sh_wa_reg     <= '0;
            sh_we_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_res_reg   <= '0;
            out_wa_reg    <= '0;
            out_we_reg    <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (state_reg == SHIFT) begin
                // The slot was freed when the shift was accepted, so it is empty here.
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg - SW'(1);
                if (cnt_reg == SW'(1)) begin
                    out_res_reg   <= acc_step;
                    out_wa_reg    <= sh_wa_reg;
                    out_we_reg    <= sh_we_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            end else if (accept) begin
                if (is_shift && (shamt != '0)) begin
                    acc_reg   <= in_n1;
                    cnt_reg   <= shamt;
                    left_reg  <= (in_st == 3'b001);
                    arith_reg <= in_sst;
                    sh_wa_reg <= in_wa;
                    sh_we_reg <= alu_we;
                    state_reg <= SHIFT;
                end else begin
                    out_res_reg   <= alu_res;
                    out_wa_reg    <= in_wa;
                    out_we_reg    <= alu_we;
                    out_valid_reg <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_alu.sv
// Directed bench for ex_alu: a transaction-level model predicts every output beat and its arrival cycle.
`timescale 1ns/1ps
module tb_ex_alu;
    localparam logic [6:0] T_OP  = 7'b0110011;
    localparam logic [6:0] T_IMM = 7'b0010011;
    localparam logic [6:0] T_LUI = 7'b0110111;
`ifdef EX_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_t = '0;
    logic [2:0]  in_st = '0;
    logic        in_sst = 1'b0;
    logic [31:0] in_n1 = '0;
    logic [31:0] in_n2 = '0;
    logic [4:0]  in_wa = '0;
    logic        in_we = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_res;
    logic [4:0]  out_wa;
    logic        out_we;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int timeouts = 0;
    int tmo_seen = 0;

    int          lit_cyc = -1;
    string       lit_name = "";
    logic [31:0] lit_res = '0;
    logic [4:0]  lit_wa = '0;
    logic        lit_we = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    ex_alu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_t(in_t), .in_st(in_st), .in_sst(in_sst),
        .in_n1(in_n1), .in_n2(in_n2), .in_wa(in_wa), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_wa(out_wa), .out_we(out_we)
    );

    always #5 clk = ~clk;

    // Result per the instruction-set definition, not the datapath structure.
    function automatic void model(input logic [6:0] t, input logic [2:0] st, input logic sst,
                                  input logic [31:0] a, input logic [31:0] b, input logic we,
                                  output logic [31:0] r, output logic w);
        int sh;
        sh = int'(b[4:0]);
        r = 32'd0;
        w = we;
        if (t == T_LUI) begin
            r = b;
        end else if (t == T_OP || t == T_IMM) begin
            case (st)
                3'd0: r = (t == T_OP && sst) ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: if ($signed(a) < $signed(b)) r = 32'd1;
                3'd3: if (a < b) r = 32'd1;
                3'd4: r = a ^ b;
                3'd5: begin
                    r = a >> sh;
                    if (sst && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else begin
            w = 1'b0;
        end
    endfunction

    function automatic int model_lat(input logic [6:0] t, input logic [2:0] st, input logic [31:0] b);
        if (!FAST && (t == T_OP || t == T_IMM) && (st == 3'd1 || st == 3'd5)) return int'(b[4:0]);
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare process: outputs checked every cycle, model advanced to the next edge.
    always @(negedge clk) begin
        bit   full, busy, exp_rdy;
        exp_t e;
        if (!rst) begin
            exp_q.delete();
            chk("reset_out_res", out_res, 32'd0);
            chk("reset_out_wa", 32'(out_wa), 32'd0);
            chk("reset_out_we", 32'(out_we), 32'd0);
        end
        full    = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        busy    = (exp_q.size() > 0) && (exp_q[0].due > cyc);
        exp_rdy = rst && !flush && !busy && (!full || out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(full));
        if (full) begin
            chk("out_res", out_res, exp_q[0].res);
            chk("out_wa", 32'(out_wa), 32'(exp_q[0].wa));
            chk("out_we", 32'(out_we), 32'(exp_q[0].we));
        end
        if (cyc == lit_cyc) begin
            chk({lit_name, "_valid"}, 32'(out_valid), 32'd1);
            chk({lit_name, "_res"}, out_res, lit_res);
            chk({lit_name, "_wa"}, 32'(out_wa), 32'(lit_wa));
            chk({lit_name, "_we"}, 32'(out_we), 32'(lit_we));
        end
        if (timeouts != tmo_seen) begin
            chk("handshake_timeout", 32'(timeouts), 32'(tmo_seen));
            tmo_seen = timeouts;
        end
        if (out_valid && out_ready && !flush && rst)
            $display("cycle %0d: beat res=%h wa=%0d we=%0d", cyc, out_res, out_wa, out_we);
        if (rst) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (full && out_ready) void'(exp_q.pop_front());
                if (in_valid && exp_rdy) begin
                    model(in_t, in_st, in_sst, in_n1, in_n2, in_we, e.res, e.we);
                    e.wa  = in_wa;
                    e.due = cyc + 1 + model_lat(in_t, in_st, in_n2);
                    exp_q.push_back(e);
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [6:0] t, input logic [2:0] st, input logic sst,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wa, input logic we);
        in_t = t; in_st = st; in_sst = sst; in_n1 = a; in_n2 = b; in_wa = wa; in_we = we;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !in_ready; n++) step();
        if (!in_ready) timeouts++;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_at(input int ofs, input string name, input logic [31:0] res,
                             input logic [4:0] wa, input logic we);
        lit_cyc = cyc + ofs; lit_name = name; lit_res = res; lit_wa = wa; lit_we = we;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b1;
        step();

        drive_op(T_OP, 3'd0, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1);
        expect_at(0, "add", 32'd12, 5'd3, 1'b1);
        drive_op(T_OP, 3'd0, 1'b1, 32'd5, 32'd7, 5'd4, 1'b1);
        expect_at(0, "sub", 32'hFFFF_FFFE, 5'd4, 1'b1);
        drive_op(T_OP, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        expect_at(0, "slt", 32'd1, 5'd5, 1'b1);
        drive_op(T_OP, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1);
        expect_at(0, "sltu", 32'd0, 5'd6, 1'b1);
        drive_op(T_IMM, 3'd0, 1'b1, 32'd100, 32'hFFFF_FFFF, 5'd7, 1'b1);
        expect_at(0, "addi_sst", 32'd99, 5'd7, 1'b1);
        drive_op(T_OP, 3'd4, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 5'd8, 1'b1);
        expect_at(0, "xor", 32'h0000_0FF0, 5'd8, 1'b1);
        drive_op(T_IMM, 3'd6, 1'b0, 32'h1200_0034, 32'h0000_0F00, 5'd9, 1'b1);
        drive_op(T_OP, 3'd7, 1'b0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd10, 1'b0);
        drive_op(T_LUI, 3'd0, 1'b0, 32'h1111_1111, 32'hABCD_E000, 5'd11, 1'b1);
        expect_at(0, "lui", 32'hABCD_E000, 5'd11, 1'b1);

        drive_op(T_IMM, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 5'd12, 1'b1);
        expect_at(FAST ? 0 : 4, "sra", 32'hF800_0000, 5'd12, 1'b1);
        repeat (6) step();
        drive_op(T_OP, 3'd5, 1'b0, 32'h8000_0000, 32'd3, 5'd13, 1'b1);
        expect_at(FAST ? 0 : 3, "srl", 32'h1000_0000, 5'd13, 1'b1);
        repeat (5) step();
        drive_op(T_OP, 3'd1, 1'b0, 32'h1234_5678, 32'd0, 5'd14, 1'b1);
        expect_at(0, "sll0", 32'h1234_5678, 5'd14, 1'b1);
        drive_op(T_IMM, 3'd1, 1'b0, 32'h0000_0003, 32'd31, 5'd15, 1'b1);
        drive_op(T_OP, 3'd5, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd16, 1'b1);

        drive_op(T_OP, 3'd0, 1'b0, 32'd40, 32'd2, 5'd17, 1'b1);
        expect_at(0, "stall_add", 32'd42, 5'd17, 1'b1);
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        repeat (2) step();

        drive_op(T_OP, 3'd1, 1'b0, 32'd1, 32'd10, 5'd18, 1'b1);
        repeat (2) step();
        flush = 1'b1;
        in_t = T_OP; in_st = 3'd0; in_n1 = 32'd1; in_n2 = 32'd1; in_valid = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (12) step();

        drive_op(T_OP, 3'd0, 1'b0, 32'd9, 32'd9, 5'd19, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        drive_op(7'h7F, 3'd0, 1'b0, 32'd3, 32'd4, 5'd20, 1'b1);
        expect_at(0, "unknown", 32'd0, 5'd20, 1'b0);

        for (int i = 0; i < 6; i++)
            drive_op(T_OP, 3'd0, 1'b0, 32'(i), 32'd100, 5'(i + 21), 1'b1);

        drive_op(T_OP, 3'd1, 1'b0, 32'd1, 32'd20, 5'd27, 1'b1);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();

        drive_op(T_OP, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd28, 1'b1);
        expect_at(0, "wrap_add", 32'd1, 5'd28, 1'b1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
